pc_next_unit: RTL and testbench
===============================

// Module: pc_next_unit
// PURPOSE
//   Program-counter register with next-address selection for the KGPminiRISC fetch stage.
//   Generalises the combinational next-address select: it holds the PC and supports parametrised widths.
//   Supported next-address modes: sequential, absolute jump, register jump and PC-relative branch.
//   It adds call/return through a DEPTH-entry return-address stack (RAS), a stall enable and a halt state.
//   It sits between the control unit (sel/taken) and instruction memory (pc).
// PARAMETERS
//   ADDR_W     32  PC / address width in bits
//   JTGT_W     26  absolute jump-target field width; zero-extended to ADDR_W (JTGT_W <= ADDR_W)
//   IMM_W      16  branch offset width; sign-extended to ADDR_W (IMM_W <= ADDR_W)
//   RAS_DEPTH  4   return-address stack entries (power of 2, >= 2)
//   PC_STEP    4   sequential increment in bytes
//   RESET_PC   0   PC value loaded by reset
// PORTS
//   clk          in   1                    rising-edge clock
//   rst          in   1                    synchronous reset, active-high
//   en           in   1                    advance PC this cycle; 0 = stall (all state holds)
//   sel          in   3                    next-address mode (see BEHAVIOUR)
//   taken        in   1                    branch condition, used only when sel=3'b011
//   jtgt         in   JTGT_W               absolute jump/call target field
//   rtgt         in   ADDR_W               register target (jr)
//   imm          in   IMM_W                signed branch offset
//   pc           out  ADDR_W               current PC (registered)
//   pc_valid     out  1                    pc is a fetchable address
//   halted       out  1                    unit is in HALT
//   ras_count    out  $clog2(RAS_DEPTH)+1  valid RAS entries, 0..RAS_DEPTH
//   ras_ovf      out  1                    sticky: a call pushed while the RAS was full
//   ras_unf      out  1                    sticky: a return popped while the RAS was empty
// BEHAVIOUR
//   Reset (rst=1 at edge):
//     - pc=RESET_PC, pc_valid=0, halted=0, ras_count=0, ras_ovf=0, ras_unf=0, state=BOOT.
//     - Applies mid-operation too; RAS contents are discarded.
//   FSM BOOT -> RUN -> HALT:
//     - BOOT: one cycle, unconditional move to RUN; pc is not updated.
//     - RUN: pc_valid=1.
//     - HALT: pc_valid=0, halted=1, pc frozen. Exited only by rst.
//   In RUN with en=0: pc, RAS and flags hold; sel is ignored.
//   In RUN with en=1, seq = pc+PC_STEP; pc updates at the edge per sel:
//     000 SEQ   pc <= seq
//     001 JMP   pc <= zext(jtgt)
//     010 JR    pc <= rtgt
//     011 BR    pc <= taken ? seq + sext(imm) : seq
//     100 CALL  pc <= zext(jtgt); push seq onto the RAS
//     101 RET   pc <= top of RAS; pop
//     110 HALT  pc holds; state <= HALT
//     111 rsvd  treated as SEQ
//   All address arithmetic is modulo 2^ADDR_W; wrap-around is silent (no flag).
//   RAS is circular, with a top pointer and ras_count:
//     - CALL when full: the oldest entry is overwritten; ras_count stays RAS_DEPTH; ras_ovf <= 1.
//     - RET when empty: pc <= rtgt (fallback); ras_count stays 0; ras_unf <= 1.
//   Flags clear only on rst. Latency: a new sel takes effect on pc one cycle later.
//   There are no combinational paths from inputs to outputs.
// TESTING
//   1. rst for 2 cycles, then en=1, sel=000 -> BOOT cycle has pc=0, pc_valid=0.
//      Then pc_valid=1 and pc = 0, 4, 8 on successive cycles.
//   2. At pc=0x10: sel=011, imm=16'hFFF8, taken=1 -> pc=0x0C next cycle.
//      Same with taken=0 -> pc=0x14.
//   3. At pc=0x100: CALL jtgt=26'h40 -> pc=0x40, ras_count=1.
//      Then RET -> pc=0x104, ras_count=0, ras_unf=0.
//   4. Five CALLs with RAS_DEPTH=4 -> ras_ovf=1, ras_count=4.
//      Four RETs return the 5th..2nd pushed addresses; a 5th RET yields rtgt and ras_unf=1.
//   5. pc=32'hFFFF_FFFC with sel=000 -> pc=0.
//      en=0 for 3 cycles with sel=001 -> pc, ras_count unchanged.
//   6. sel=110 -> halted=1, pc_valid=0, pc frozen across any sel/en.
//      rst mid-HALT -> pc=RESET_PC, halted=0, flags and ras_count cleared.

Source files
------------

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_unit
//  Description : Program-counter register with next-address selection for
//                the KGPminiRISC fetch stage. Holds the PC and selects the next
//                address (sequential, absolute jump, register jump, PC-relative
//                branch, call, return, halt). Calls and returns use a circular
//                return-address stack. Supports a stall enable and a terminal
//                HALT state.
//  Ports       :
//    clk        - rising-edge clock
//    rst        - synchronous reset, active-high
//    en         - advance PC this cycle (0 = stall, all state holds)
//    sel        - next-address mode
//    taken      - branch condition (used only by BR)
//    jtgt       - absolute jump/call target field (zero-extended)
//    rtgt       - register target (JR, and RET fallback on empty stack)
//    imm        - signed branch offset (sign-extended)
//    pc         - current PC (registered)
//    pc_valid   - pc is a fetchable address
//    halted     - unit is in HALT
//    ras_count  - number of valid return-stack entries, 0..RAS_DEPTH
//    ras_ovf    - sticky: a call pushed while the stack was full
//    ras_unf    - sticky: a return popped while the stack was empty
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       JTGT_W    = 26,
    parameter int unsigned       IMM_W     = 16,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter int unsigned       PC_STEP   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [2:0]                   sel,
    input  logic                         taken,
    input  logic [JTGT_W-1:0]            jtgt,
    input  logic [ADDR_W-1:0]            rtgt,
    input  logic [IMM_W-1:0]             imm,
    output logic [ADDR_W-1:0]            pc,
    output logic                         pc_valid,
    output logic                         halted,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned c_ptr_w = $clog2(RAS_DEPTH);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;

    localparam logic [c_cnt_w-1:0] c_ras_full = c_cnt_w'(RAS_DEPTH);
    localparam logic [ADDR_W-1:0]  c_step     = ADDR_W'(PC_STEP);

    localparam logic [2:0] c_sel_jmp  = 3'b001;
    localparam logic [2:0] c_sel_jr   = 3'b010;
    localparam logic [2:0] c_sel_br   = 3'b011;
    localparam logic [2:0] c_sel_call = 3'b100;
    localparam logic [2:0] c_sel_ret  = 3'b101;
    localparam logic [2:0] c_sel_halt = 3'b110;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_pc_valid;
    logic                r_halted;
    logic [c_ptr_w-1:0]  r_top;
    logic [c_cnt_w-1:0]  r_ras_count;
    logic                r_ras_ovf;
    logic                r_ras_unf;
    logic [ADDR_W-1:0]   r_ras [RAS_DEPTH];

    // ------------------------------------------------------------------------
    // Next-address selection
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0]   w_seq;
    logic [ADDR_W-1:0]   w_jtgt_ext;
    logic [ADDR_W-1:0]   w_imm_ext;
    logic [ADDR_W-1:0]   w_br_tgt;
    logic [ADDR_W-1:0]   w_next_pc;
    logic [c_ptr_w-1:0]  w_push_ptr;
    logic                w_advance;
    logic                w_ras_empty;
    logic                w_ras_full;
    logic                w_push;
    logic                w_pop;
    logic                w_halt_req;

    always_comb begin
        w_seq       = r_pc + c_step;
        // Sized casts: unsigned source zero-extends, signed source sign-extends.
        w_jtgt_ext  = ADDR_W'(jtgt);
        w_imm_ext   = ADDR_W'($signed(imm));
        w_br_tgt    = w_seq + w_imm_ext;
        w_advance   = (r_state == ST_RUN) && en;
        w_ras_empty = (r_ras_count == '0);
        w_ras_full  = (r_ras_count == c_ras_full);
        // The slot above the top is free, or holds the oldest entry when full,
        // so a push always writes there.
        w_push_ptr  = r_top + 1'b1;

        w_next_pc   = r_pc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_halt_req  = 1'b0;

        if (w_advance) begin
            case (sel)
                c_sel_jmp:  w_next_pc = w_jtgt_ext;
                c_sel_jr:   w_next_pc = rtgt;
                c_sel_br:   w_next_pc = taken ? w_br_tgt : w_seq;
                c_sel_call: begin
                    w_next_pc = w_jtgt_ext;
                    w_push    = 1'b1;
                end
                c_sel_ret:  begin
                    // An empty stack falls back to the register target.
                    w_next_pc = w_ras_empty ? rtgt : r_ras[r_top];
                    w_pop     = 1'b1;
                end
                c_sel_halt: begin
                    w_next_pc  = r_pc;
                    w_halt_req = 1'b1;
                end
                // 3'b000 SEQ and the reserved 3'b111 both step sequentially.
                default:    w_next_pc = w_seq;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM, PC register, stack pointer/count and sticky flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_PC;
            r_pc_valid  <= 1'b0;
            r_halted    <= 1'b0;
            r_top       <= '1;
            r_ras_count <= '0;
            r_ras_ovf   <= 1'b0;
            r_ras_unf   <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    // Single settling cycle; pc keeps RESET_PC.
                    r_state    <= ST_RUN;
                    r_pc_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (w_advance) begin
                        r_pc <= w_next_pc;

                        if (w_halt_req) begin
                            r_state    <= ST_HALT;
                            r_pc_valid <= 1'b0;
                            r_halted   <= 1'b1;
                        end

                        if (w_push) begin
                            r_top <= w_push_ptr;
                            if (w_ras_full) begin
                                r_ras_ovf <= 1'b1;
                            end else begin
                                r_ras_count <= r_ras_count + 1'b1;
                            end
                        end

                        if (w_pop) begin
                            if (w_ras_empty) begin
                                r_ras_unf <= 1'b1;
                            end else begin
                                r_top       <= r_top - 1'b1;
                                r_ras_count <= r_ras_count - 1'b1;
                            end
                        end
                    end
                end
                ST_HALT: begin
                    // Terminal until reset; everything holds.
                end
                default: begin
                    r_state    <= ST_BOOT;
                    r_pc_valid <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    // Stack storage needs no reset: ras_count defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_ras[w_push_ptr] <= w_seq;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------------
    assign pc        = r_pc;
    assign pc_valid  = r_pc_valid;
    assign halted    = r_halted;
    assign ras_count = r_ras_count;
    assign ras_ovf   = r_ras_ovf;
    assign ras_unf   = r_ras_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_next_unit
//  Description : Self-checking bench for pc_next_unit. Directed scenarios
//                plus randomized traffic compared against a queue-based
//                reference model of the PC and return stack.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_next_unit;

    localparam int unsigned RAS_DEPTH = 4;

    localparam logic [2:0] SEQ  = 3'b000;
    localparam logic [2:0] JMP  = 3'b001;
    localparam logic [2:0] JR   = 3'b010;
    localparam logic [2:0] BR   = 3'b011;
    localparam logic [2:0] CALL = 3'b100;
    localparam logic [2:0] RET  = 3'b101;
    localparam logic [2:0] HALT = 3'b110;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  sel;
    logic        taken;
    logic [25:0] jtgt;
    logic [31:0] rtgt;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        pc_valid;
    logic        halted;
    logic [2:0]  ras_count;
    logic        ras_ovf;
    logic        ras_unf;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_boot, m_valid, m_halted, m_ovf, m_unf;
    logic [31:0] m_ras [$];

    pc_next_unit #(
        .ADDR_W    (32),
        .JTGT_W    (26),
        .IMM_W     (16),
        .RAS_DEPTH (RAS_DEPTH),
        .PC_STEP   (4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sel       (sel),
        .taken     (taken),
        .jtgt      (jtgt),
        .rtgt      (rtgt),
        .imm       (imm),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .halted    (halted),
        .ras_count (ras_count),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Apply one cycle of inputs, let the edge happen, then advance the model.
    task automatic cycle(input bit r, input bit e, input logic [2:0] s, input bit t,
                         input logic [25:0] j, input logic [31:0] rt, input logic [15:0] im);
        logic [31:0] seq;
        rst = r; en = e; sel = s; taken = t; jtgt = j; rtgt = rt; imm = im;
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = 32'h0; m_boot = 1; m_valid = 0; m_halted = 0;
            m_ovf = 0; m_unf = 0; m_ras.delete();
        end else if (m_boot) begin
            m_boot = 0; m_valid = 1;
        end else if (!m_halted && e) begin
            seq = m_pc + 32'd4;
            case (s)
                JMP:  m_pc = {6'b0, j};
                JR:   m_pc = rt;
                BR:   m_pc = t ? seq + {{16{im[15]}}, im} : seq;
                CALL: begin
                    m_ras.push_back(seq);
                    if (m_ras.size() > RAS_DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1;
                    end
                    m_pc = {6'b0, j};
                end
                RET: begin
                    if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                    else begin m_pc = rt; m_unf = 1; end
                end
                HALT: begin m_halted = 1; m_valid = 0; end
                default: m_pc = seq;
            endcase
        end
    endtask

    task automatic do_reset();
        cycle(1, 0, SEQ, 0, 26'h0, 32'h0, 16'h0);
        cycle(1, 0, SEQ, 0, 26'h0, 32'h0, 16'h0);
        cycle(0, 1, SEQ, 0, 26'h0, 32'h0, 16'h0); // BOOT -> RUN
    endtask

    task automatic test_reset();
        cycle(1, 0, SEQ, 0, 26'h0, 32'h0, 16'h0);
        cycle(1, 1, SEQ, 0, 26'h0, 32'h0, 16'h0);
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", pc_valid); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (ras_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", ras_count); end
        n_cmp++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin n_err++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0/0", ras_ovf, ras_unf); end
        cycle(0, 1, SEQ, 0, 26'h0, 32'h0, 16'h0);
        n_cmp++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin n_err++; $display("FAIL boot_exit: got pc=%h valid=%b want 0/1", pc, pc_valid); end
        cycle(0, 1, SEQ, 0, 26'h0, 32'h0, 16'h0);
        n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL seq_1: got %h want %h", pc, 32'h4); end
        cycle(0, 1, SEQ, 0, 26'h0, 32'h0, 16'h0);
        n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL seq_2: got %h want %h", pc, 32'h8); end
    endtask

    task automatic test_branch();
        cycle(0, 1, JR, 0, 26'h0, 32'h10, 16'h0);
        n_cmp++; if (pc !== 32'h10) begin n_err++; $display("FAIL jr_setup: got %h want %h", pc, 32'h10); end
        cycle(0, 1, BR, 1, 26'h0, 32'h0, 16'hFFF8);
        n_cmp++; if (pc !== 32'h0C) begin n_err++; $display("FAIL br_taken: got %h want %h", pc, 32'h0C); end
        cycle(0, 1, JR, 0, 26'h0, 32'h10, 16'h0);
        cycle(0, 1, BR, 0, 26'h0, 32'h0, 16'hFFF8);
        n_cmp++; if (pc !== 32'h14) begin n_err++; $display("FAIL br_not_taken: got %h want %h", pc, 32'h14); end
        cycle(0, 1, JMP, 0, 26'h3FF_FFFC, 32'h0, 16'h0);
        n_cmp++; if (pc !== 32'h03FF_FFFC) begin n_err++; $display("FAIL jmp_zext: got %h want %h", pc, 32'h03FF_FFFC); end
    endtask

    task automatic test_call_ret();
        do_reset();
        cycle(0, 1, JR, 0, 26'h0, 32'h100, 16'h0);
        cycle(0, 1, CALL, 0, 26'h40, 32'h0, 16'h0);
        n_cmp++; if (pc !== 32'h40 || ras_count !== 3'd1) begin n_err++; $display("FAIL call: got pc=%h cnt=%0d want 40/1", pc, ras_count); end
        cycle(0, 1, RET, 0, 26'h0, 32'hBAD0, 16'h0);
        n_cmp++; if (pc !== 32'h104 || ras_count !== 3'd0 || ras_unf !== 1'b0) begin n_err++; $display("FAIL ret: got pc=%h cnt=%0d unf=%b want 104/0/0", pc, ras_count, ras_unf); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] pushed [5];
        logic [31:0] cur;
        logic [31:0] tgt;
        do_reset();
        cycle(0, 1, JR, 0, 26'h0, 32'h1000, 16'h0);
        cur = 32'h1000;
        for (int i = 0; i < 5; i++) begin
            tgt = 32'h200 + 32'(i) * 32'h40;
            pushed[i] = cur + 32'd4;
            cycle(0, 1, CALL, 0, tgt[25:0], 32'h0, 16'h0);
            cur = tgt;
        end
        n_cmp++; if (ras_ovf !== 1'b1 || ras_count !== 3'd4) begin n_err++; $display("FAIL ovf: got ovf=%b cnt=%0d want 1/4", ras_ovf, ras_count); end
        for (int i = 4; i >= 1; i--) begin
            cycle(0, 1, RET, 0, 26'h0, 32'hDEAD0000, 16'h0);
            n_cmp++;
            if (pc !== pushed[i] || ras_count !== 3'(i - 1)) begin
                n_err++; $display("FAIL ret_order_%0d: got pc=%h cnt=%0d want %h/%0d", i, pc, ras_count, pushed[i], i - 1);
            end
        end
        cycle(0, 1, RET, 0, 26'h0, 32'h1234, 16'h0);
        n_cmp++; if (pc !== 32'h1234 || ras_unf !== 1'b1 || ras_count !== 3'd0) begin n_err++; $display("FAIL unf: got pc=%h unf=%b cnt=%0d want 1234/1/0", pc, ras_unf, ras_count); end
    endtask

    task automatic test_wrap_stall();
        do_reset();
        cycle(0, 1, JR, 0, 26'h0, 32'hFFFF_FFFC, 16'h0);
        cycle(0, 1, SEQ, 0, 26'h0, 32'h0, 16'h0);
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap: got %h want 0", pc); end
        cycle(0, 1, CALL, 0, 26'h80, 32'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, JMP, 0, 26'h3FF, 32'h0, 16'h0);
            n_cmp++;
            if (pc !== 32'h80 || ras_count !== 3'd1) begin n_err++; $display("FAIL stall_%0d: got pc=%h cnt=%0d want 80/1", i, pc, ras_count); end
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, 1, CALL, 0, 26'(32'h300 + 32'(i) * 4), 32'h0, 16'h0);
        cycle(0, 1, HALT, 0, 26'h0, 32'h0, 16'h0);
        n_cmp++; if (halted !== 1'b1 || pc_valid !== 1'b0 || pc !== 32'h310) begin n_err++; $display("FAIL halt_enter: got h=%b v=%b pc=%h want 1/0/310", halted, pc_valid, pc); end
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1, 26'h155, 32'h777, 16'h8);
            n_cmp++;
            if (pc !== 32'h310 || halted !== 1'b1 || pc_valid !== 1'b0) begin n_err++; $display("FAIL halt_hold_%0d: got pc=%h h=%b v=%b want 310/1/0", i, pc, halted, pc_valid); end
        end
        cycle(1, 1, SEQ, 0, 26'h0, 32'h0, 16'h0);
        n_cmp++;
        if (pc !== 32'h0 || halted !== 1'b0 || ras_count !== 3'd0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
            n_err++; $display("FAIL halt_reset: got pc=%h h=%b cnt=%0d ovf=%b unf=%b want 0/0/0/0/0", pc, halted, ras_count, ras_ovf, ras_unf);
        end
    endtask

    task automatic test_random();
        bit          r, e;
        logic [2:0]  s;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 49) == 0);
            e = ($urandom_range(0, 3) != 0);
            s = 3'($urandom_range(0, 7));
            if (s == HALT && $urandom_range(0, 7) != 0) s = SEQ;
            cycle(r, e, s, 1'($urandom), 26'($urandom), $urandom, 16'($urandom));
            n_cmp++;
            if (pc !== m_pc || pc_valid !== m_valid || halted !== m_halted ||
                ras_count !== 3'(m_ras.size()) || ras_ovf !== m_ovf || ras_unf !== m_unf) begin
                n_err++;
                $display("FAIL random_%0d: got pc=%h v=%b h=%b cnt=%0d ovf=%b unf=%b want pc=%h v=%b h=%b cnt=%0d ovf=%b unf=%b",
                         n, pc, pc_valid, halted, ras_count, ras_ovf, ras_unf,
                         m_pc, m_valid, m_halted, m_ras.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_call_ret();
        test_ras_overflow();
        test_wrap_stall();
        test_halt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
